// File: rtl/ara_pkg.sv
// Shared types and limits for the lane operand queues.
package ara_pkg;

    localparam int unsigned OqBeatsWidth = 16;
    localparam int unsigned OqMaxDepth   = 16;

    typedef struct packed {
        logic [OqBeatsWidth-1:0] beats;
    } oq_cmd_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic registered FIFO, no fall-through: a push is readable the cycle after.
// Push is accepted while full only alongside a pop; flush empties and wins over push/pop.
module fifo_v3 #(
    parameter int unsigned DEPTH   = 4,
    parameter type         dtype_t = logic [31:0]
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH + 1)-1:0]   usage_o,
    input  dtype_t                         data_i,
    input  logic                           push_i,
    output dtype_t                         data_o,
    input  logic                           pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    dtype_t           mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
        return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/operand_queue_chan.sv
// One operand channel: credit-tracked data FIFO plus command FIFO giving a last-beat flag.
// Data visible one cycle after arrival; credits and all handshake outputs come from registers only.
module operand_queue_chan
    import ara_pkg::*;
#(
    parameter int unsigned Depth      = 4,
    parameter int unsigned CmdDepth   = 2,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned BeatsWidth = OqBeatsWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] operand_i,
    input  logic                 operand_valid_i,
    input  logic                 operand_issued_i,
    output logic                 operand_queue_ready_o,
    input  oq_cmd_t              cmd_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 flush_i,
    output logic [DataWidth-1:0] operand_o,
    output logic                 operand_valid_o,
    input  logic                 operand_ready_i,
    output logic                 operand_last_o
);

    localparam int unsigned CntW    = $clog2(Depth + 1);
    localparam int unsigned CmdCntW = $clog2(CmdDepth + 1);

    logic [CntW-1:0]       inflight_q, inflight_d, discard_q, discard_d, occ;
    logic [CntW:0]         credit_sum;
    logic [BeatsWidth-1:0] beat_idx_q, beat_idx_d;
    logic [CmdCntW-1:0]    cmd_usage;
    logic                  data_full, data_empty, data_push, data_pop, drop;
    logic                  cmd_full, cmd_empty, cmd_push, cmd_pop, is_last;
    oq_cmd_t               cmd_head;

    assign drop       = operand_valid_i && (discard_q != '0);
    assign data_push  = operand_valid_i && !drop;
    assign credit_sum = {1'b0, occ} + {1'b0, inflight_q};

    assign operand_queue_ready_o = (credit_sum < (CntW + 1)'(Depth));
    assign cmd_ready_o           = !cmd_full;
    assign cmd_push              = cmd_valid_i && cmd_ready_o;

    // The active command stays at the FIFO head; beat_idx counts pops within it.
    assign is_last         = (beat_idx_q == BeatsWidth'(cmd_head.beats - 1'b1));
    assign operand_valid_o = !data_empty && !cmd_empty;
    assign operand_last_o  = operand_valid_o && is_last;
    assign data_pop        = operand_valid_o && operand_ready_i;
    assign cmd_pop         = data_pop && is_last;

    fifo_v3 #(
        .DEPTH   (Depth),
        .dtype_t (logic [DataWidth-1:0])
    ) i_data_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (data_full),
        .empty_o (data_empty),
        .usage_o (occ),
        .data_i  (operand_i),
        .push_i  (data_push),
        .data_o  (operand_o),
        .pop_i   (data_pop)
    );

    fifo_v3 #(
        .DEPTH   (CmdDepth),
        .dtype_t (oq_cmd_t)
    ) i_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .usage_o (cmd_usage),
        .data_i  (cmd_i),
        .push_i  (cmd_push),
        .data_o  (cmd_head),
        .pop_i   (cmd_pop)
    );

    always_comb begin
        inflight_d = inflight_q;
        discard_d  = discard_q;
        beat_idx_d = beat_idx_q;
        case ({operand_issued_i, operand_valid_i})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (drop) discard_d = discard_q - CntW'(1);
        if (data_pop) beat_idx_d = is_last ? '0 : beat_idx_q + BeatsWidth'(1);
        // Every read still outstanding after this cycle belongs to the flushed stream.
        if (flush_i) begin
            discard_d  = inflight_d;
            beat_idx_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
            discard_q  <= '0;
            beat_idx_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            beat_idx_q <= beat_idx_d;
        end
    end

    a_zero_beats: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cmd_push && cmd_i.beats == '0));
    a_arrival_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(operand_valid_i && inflight_q == '0));
    a_issue_without_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(operand_issued_i && !operand_queue_ready_o));
    a_push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_push && data_full && !data_pop && !flush_i));
    a_cmd_usage: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cmd_usage <= CmdCntW'(CmdDepth));

endmodule

// File: rtl/operand_queue_array.sv
// Array of independent operand queue channels between the VRF requester and the functional units.
// Per-channel latency and backpressure are those of operand_queue_chan.
module operand_queue_array
    import ara_pkg::*;
#(
    parameter int unsigned NrQueues             = 9,
    parameter int unsigned DataWidth            = 64,
    parameter int unsigned QueueDepth [NrQueues] = '{default: 4},
    parameter int unsigned CmdDepth             = 2,
    parameter int unsigned BeatsWidth           = OqBeatsWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrQueues-1:0][DataWidth-1:0]  operand_i,
    input  logic [NrQueues-1:0]                 operand_valid_i,
    input  logic [NrQueues-1:0]                 operand_issued_i,
    output logic [NrQueues-1:0]                 operand_queue_ready_o,
    input  oq_cmd_t [NrQueues-1:0]              cmd_i,
    input  logic [NrQueues-1:0]                 cmd_valid_i,
    output logic [NrQueues-1:0]                 cmd_ready_o,
    input  logic [NrQueues-1:0]                 flush_i,
    output logic [NrQueues-1:0][DataWidth-1:0]  operand_o,
    output logic [NrQueues-1:0]                 operand_valid_o,
    input  logic [NrQueues-1:0]                 operand_ready_i,
    output logic [NrQueues-1:0]                 operand_last_o
);

    for (genvar q = 0; q < NrQueues; q++) begin : g_chan
        a_depth_range: assert property (@(posedge clk_i)
            QueueDepth[q] >= 1 && QueueDepth[q] <= OqMaxDepth);

        operand_queue_chan #(
            .Depth      (QueueDepth[q]),
            .CmdDepth   (CmdDepth),
            .DataWidth  (DataWidth),
            .BeatsWidth (BeatsWidth)
        ) i_chan (
            .clk_i                 (clk_i),
            .rst_ni                (rst_ni),
            .operand_i             (operand_i[q]),
            .operand_valid_i       (operand_valid_i[q]),
            .operand_issued_i      (operand_issued_i[q]),
            .operand_queue_ready_o (operand_queue_ready_o[q]),
            .cmd_i                 (cmd_i[q]),
            .cmd_valid_i           (cmd_valid_i[q]),
            .cmd_ready_o           (cmd_ready_o[q]),
            .flush_i               (flush_i[q]),
            .operand_o             (operand_o[q]),
            .operand_valid_o       (operand_valid_o[q]),
            .operand_ready_i       (operand_ready_i[q]),
            .operand_last_o        (operand_last_o[q])
        );
    end

endmodule

// File: tb/tb_operand_queue_array.sv
// Directed bench for operand_queue_array: per-cycle stimulus rows with hand-derived expectations.
module tb_operand_queue_array;
    import ara_pkg::*;

    localparam int NQ = 9;
    localparam int DW = 64;
    localparam logic [DW-1:0] NOD = '0;
    localparam logic [DW-1:0] XD  = 64'h0BAD_0BAD_0BAD_0BAD;

    logic                  clk, rst_n;
    logic [NQ-1:0][DW-1:0] operand_i, operand_o;
    logic [NQ-1:0]         operand_valid_i, operand_issued_i, operand_queue_ready_o;
    oq_cmd_t [NQ-1:0]      cmd_i;
    logic [NQ-1:0]         cmd_valid_i, cmd_ready_o, flush_i;
    logic [NQ-1:0]         operand_valid_o, operand_ready_i, operand_last_o;
    logic [NQ-1:0]         cons_rdy;
    int                    n_checks, n_fail, cyc_no;

    operand_queue_array #(
        .NrQueues   (NQ),
        .DataWidth  (DW),
        .QueueDepth ('{4, 2, 8, 4, 4, 4, 4, 4, 4}),
        .CmdDepth   (2),
        .BeatsWidth (16)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .operand_i             (operand_i),
        .operand_valid_i       (operand_valid_i),
        .operand_issued_i      (operand_issued_i),
        .operand_queue_ready_o (operand_queue_ready_o),
        .cmd_i                 (cmd_i),
        .cmd_valid_i           (cmd_valid_i),
        .cmd_ready_o           (cmd_ready_o),
        .flush_i               (flush_i),
        .operand_o             (operand_o),
        .operand_valid_o       (operand_valid_o),
        .operand_ready_i       (operand_ready_i),
        .operand_last_o        (operand_last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] dv(input int i);
        return 64'hCAFE_0000_0000_0000 | DW'(i);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic clear_inputs();
        operand_i        = '0;
        operand_valid_i  = '0;
        operand_issued_i = '0;
        cmd_i            = '0;
        cmd_valid_i      = '0;
        flush_i          = '0;
        operand_ready_i  = cons_rdy;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " ready"}, 64'(operand_queue_ready_o), 64'h1FF);
        check_eq({tag, " cmd_ready"}, 64'(cmd_ready_o), 64'h1FF);
        check_eq({tag, " valid"}, 64'(operand_valid_o), 64'h0);
        check_eq({tag, " last"}, 64'(operand_last_o), 64'h0);
        check_eq({tag, " data"}, 64'(|operand_o), 64'h0);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        cons_rdy = '1;
        clear_inputs();
        tick();
        rst_n  = 1'b1;
        cyc_no = 0;
    endtask

    // Drive one cycle on channel ch, check the registered outputs of that cycle, then advance.
    task automatic cyc(input int ch, input int iss, input int arr, input logic [DW-1:0] dat,
                       input int cv, input int beats, input int fl,
                       input int e_rdy, input int e_crdy, input int e_v, input int e_l,
                       input logic [DW-1:0] e_d);
        operand_issued_i[ch] = (iss != 0);
        operand_valid_i[ch]  = (arr != 0);
        operand_i[ch]        = dat;
        cmd_valid_i[ch]      = (cv != 0);
        cmd_i[ch].beats      = 16'(beats);
        flush_i[ch]          = (fl != 0);
        operand_ready_i      = cons_rdy;
        check_eq($sformatf("c%0d q%0d ready", cyc_no, ch), 64'(operand_queue_ready_o[ch]), 64'(e_rdy));
        check_eq($sformatf("c%0d q%0d cmd_ready", cyc_no, ch), 64'(cmd_ready_o[ch]), 64'(e_crdy));
        check_eq($sformatf("c%0d q%0d valid", cyc_no, ch), 64'(operand_valid_o[ch]), 64'(e_v));
        check_eq($sformatf("c%0d q%0d last", cyc_no, ch), 64'(operand_last_o[ch]), 64'(e_l));
        if (e_v != 0)
            check_eq($sformatf("c%0d q%0d data", cyc_no, ch), operand_o[ch], e_d);
        check_eq($sformatf("c%0d others idle", cyc_no), 64'(operand_valid_o & ~(NQ'(1) << ch)), 64'h0);
        tick();
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc_no   = 0;
        cons_rdy = '1;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Depth 4: credits run out after 4 issues, then a 4-beat command drains them.
        //  ch iss arr dat    cv beats fl  rdy crdy v  l  exp
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(0), 0, 0, 0,   0, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(1), 1, 4, 0,   0, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(2), 0, 0, 0,   0, 1, 1, 0, dv(0));
        cyc(0, 0, 1, dv(3), 0, 0, 0,   1, 1, 1, 0, dv(1));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 1, 0, dv(2));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 1, 1, dv(3));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);

        // Depth 2: issue whenever a credit is free, data returns one cycle after issue.
        apply_reset();
        cyc(1, 1, 0, NOD,   1, 6, 0,   1, 1, 0, 0, NOD);
        cyc(1, 1, 1, dv(0), 0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(1, 0, 1, dv(1), 0, 0, 0,   0, 1, 1, 0, dv(0));
        cyc(1, 1, 0, NOD,   0, 0, 0,   1, 1, 1, 0, dv(1));
        cyc(1, 1, 1, dv(2), 0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(1, 0, 1, dv(3), 0, 0, 0,   0, 1, 1, 0, dv(2));
        cyc(1, 1, 0, NOD,   0, 0, 0,   1, 1, 1, 0, dv(3));
        cyc(1, 1, 1, dv(4), 0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(1, 0, 1, dv(5), 0, 0, 0,   0, 1, 1, 0, dv(4));
        cyc(1, 0, 0, NOD,   0, 0, 0,   1, 1, 1, 1, dv(5));
        cyc(1, 0, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);

        // Back-to-back commands of 2 and 3 beats over 5 elements.
        apply_reset();
        cyc(0, 1, 0, NOD,   1, 2, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   1, 3, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 0, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 0, 0, 0, NOD);
        cyc(0, 0, 1, dv(0), 0, 0, 0,   0, 0, 0, 0, NOD);
        cyc(0, 0, 1, dv(1), 0, 0, 0,   0, 0, 1, 0, dv(0));
        cyc(0, 1, 1, dv(2), 0, 0, 0,   1, 0, 1, 1, dv(1));
        cyc(0, 0, 1, dv(3), 0, 0, 0,   1, 1, 1, 0, dv(2));
        cyc(0, 0, 1, dv(4), 0, 0, 0,   1, 1, 1, 0, dv(3));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 1, 1, dv(4));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);

        // Depth 8 with a stalled consumer: flush with 3 reads in flight and 2 queued.
        apply_reset();
        cons_rdy[2] = 1'b0;
        cyc(2, 1, 0, NOD,   1, 8, 0,   1, 1, 0, 0, NOD);
        cyc(2, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(2, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(2, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(2, 1, 1, dv(0), 0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(2, 0, 1, dv(1), 0, 0, 0,   1, 1, 1, 0, dv(0));
        cyc(2, 0, 0, NOD,   0, 0, 1,   1, 1, 1, 0, dv(0));
        cyc(2, 0, 1, XD,    0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(2, 1, 1, XD,    1, 1, 0,   1, 1, 0, 0, NOD);
        cyc(2, 0, 1, XD,    0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(2, 0, 1, dv(9), 0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(2, 0, 0, NOD,   0, 0, 0,   1, 1, 1, 1, dv(9));

        // Flush together with an issue and an arrival while 2 reads are in flight.
        apply_reset();
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 1, XD,    0, 0, 1,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 0, 1, XD,    0, 0, 0,   0, 1, 0, 0, NOD);
        cyc(0, 0, 1, XD,    1, 2, 0,   1, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(6), 0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(7), 0, 0, 0,   1, 1, 1, 0, dv(6));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 1, 1, dv(7));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);

        // Maximum beat count: two elements of a 65535-beat command are never last.
        apply_reset();
        cyc(0, 1, 0, NOD,   1, 65535, 0, 1, 1, 0, 0, NOD);
        cyc(0, 1, 1, dv(10), 0, 0, 0,  1, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(11), 0, 0, 0,  1, 1, 1, 0, dv(10));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 1, 0, dv(11));
        cyc(0, 0, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);

        // Asynchronous reset with 3 elements queued behind a stalled consumer.
        apply_reset();
        cons_rdy[0] = 1'b0;
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 1, 0, NOD,   0, 0, 0,   1, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(20), 1, 3, 0,  1, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(21), 0, 0, 0,  1, 1, 1, 0, dv(20));
        cyc(0, 0, 1, dv(22), 0, 0, 0,  1, 1, 1, 0, dv(20));
        check_eq("pre-reset valid", 64'(operand_valid_o[0]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async reset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cyc_no   = 0;
        cons_rdy = '1;
        clear_inputs();
        cyc(0, 1, 0, NOD,    1, 1, 0,  1, 1, 0, 0, NOD);
        cyc(0, 0, 1, dv(30), 0, 0, 0,  1, 1, 0, 0, NOD);
        cyc(0, 0, 0, NOD,    0, 0, 0,  1, 1, 1, 1, dv(30));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
